// File: rtl/wm_pkg.sv
//------------------------------------------------------------------------------
// wm_pkg : shared types and defaults for the washing-machine controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wm_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
//------------------------------------------------------------------------------
// timer_prescaler : cycle counter producing a one-cycle tick every freq cycles
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module timer_prescaler
  import wm_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] freq,
  output logic         sec_tick
);

  logic [W-1:0] r_cyc_cnt;
  logic [W-1:0] w_last;

  // freq of zero behaves as one cycle per second
  assign w_last   = (freq == '0) ? '0 : freq - W'(1);
  assign sec_tick = en && !clr && (r_cyc_cnt == w_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cyc_cnt <= '0;
    end else if (clr) begin
      r_cyc_cnt <= '0;
    end else if (en) begin
      r_cyc_cnt <= sec_tick ? '0 : r_cyc_cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer.sv
//------------------------------------------------------------------------------
// timer : programmable seconds timer, done after clk_freq*timer_period edges
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module timer
  import wm_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] clk_freq,
  input  logic [W-1:0] timer_period,
  output logic         done
);

  timer_state_t r_state;
  logic [W-1:0] r_freq;
  logic [W-1:0] r_period;
  logic [W-1:0] r_sec_cnt;

  logic [W-1:0] w_freq;
  logic [W-1:0] w_period;
  logic [W-1:0] w_sec_next;
  logic         w_tick;
  logic         w_cnt_en;

  // The IDLE->RUN edge already counts, so it must see the live config
  assign w_freq     = (r_state == IDLE) ? clk_freq : r_freq;
  assign w_period   = (r_state == IDLE) ? timer_period : r_period;
  assign w_sec_next = r_sec_cnt + W'(1);
  assign w_cnt_en   = enable && (r_state != DONE);

  timer_prescaler #(
    .W (W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (!enable),
    .en       (w_cnt_en),
    .freq     (w_freq),
    .sec_tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_freq    <= '0;
      r_period  <= '0;
      r_sec_cnt <= '0;
      done      <= 1'b0;
    end else if (!enable) begin
      r_state   <= IDLE;
      r_sec_cnt <= '0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (r_state == IDLE) begin
            r_freq   <= clk_freq;
            r_period <= timer_period;
          end
          if (r_state == IDLE && timer_period == '0) begin
            r_state <= DONE;
            done    <= 1'b1;
          end else if (w_tick) begin
            // sec_cnt never exceeds period, so the increment cannot wrap
            r_sec_cnt <= w_sec_next;
            if (w_sec_next == w_period) begin
              r_state <= DONE;
              done    <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer.sv
//------------------------------------------------------------------------------
// tb_timer : directed scoreboard bench for the seconds timer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] clk_freq = 16'd5;
  logic [15:0] timer_period = 16'd1;
  logic        done;

  logic        exp_q[$];
  int          id_q[$];
  int          tnum = 0;
  int          n_vec = 0;
  int          n_err = 0;

  timer #(.W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .clk_freq     (clk_freq),
    .timer_period (timer_period),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s test%0d: done=%b expected %b at %0t", name, id, act, exp, $time);
    end
  endtask

  // Monitor: one expected done value per rising edge, sampled just after it
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      chk("done", id_q.pop_front(), done, exp_q.pop_front());
    end
  end

  task automatic cyc(input logic en, input logic exp);
    enable = en;
    exp_q.push_back(exp);
    id_q.push_back(tnum);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input int t, input logic [15:0] f, input logic [15:0] p);
    tnum         = t;
    clk_freq     = f;
    timer_period = p;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", 0, done, 1'b0);
    reset = 1'b1;

    // 1: freq 5, period 1 -> done after edge 5, held
    cfg(1, 16'd5, 16'd1);
    for (int e = 1; e <= 8; e++) cyc(1'b1, e >= 5);
    cyc(1'b0, 1'b0);

    // 2: freq 4, period 3 -> 12 edges
    cfg(2, 16'd4, 16'd3);
    for (int e = 1; e <= 14; e++) cyc(1'b1, e >= 12);
    cyc(1'b0, 1'b0);

    // 3: freq 5, period 2, enable dropped on edge 6 -> 10 edges after re-raise
    cfg(3, 16'd5, 16'd2);
    for (int e = 1; e <= 5; e++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    for (int e = 1; e <= 12; e++) cyc(1'b1, e >= 10);
    cyc(1'b0, 1'b0);

    // 4a: period 0 -> done on first edge
    cfg(4, 16'd5, 16'd0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);

    // 4b: freq 0 treated as 1, period 3 -> 3 edges
    cfg(5, 16'd0, 16'd3);
    for (int e = 1; e <= 4; e++) cyc(1'b1, e >= 3);
    cyc(1'b0, 1'b0);

    // 4c: freq 1, period 2 -> 2 edges
    cfg(6, 16'd1, 16'd2);
    for (int e = 1; e <= 3; e++) cyc(1'b1, e >= 2);
    cyc(1'b0, 1'b0);

    // 5: async reset mid-run aborts; after release full 6-edge count restarts
    cfg(7, 16'd3, 16'd2);
    for (int e = 1; e <= 4; e++) cyc(1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 chk("async_rst_midrun", 7, done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) cyc(1'b1, e >= 6);
    #2 reset = 1'b0;
    #1 chk("async_rst_done", 7, done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) cyc(1'b1, e >= 6);
    cyc(1'b0, 1'b0);

    // 6: period change 2->9 during RUN ignored; takes effect after IDLE
    cfg(8, 16'd2, 16'd2);
    cyc(1'b1, 1'b0);
    timer_period = 16'd9;
    for (int e = 2; e <= 6; e++) cyc(1'b1, e >= 4);
    cyc(1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) cyc(1'b1, e >= 18);
    cyc(1'b0, 1'b0);

    // Terminal count coinciding with enable=0: enable wins
    cfg(9, 16'd2, 16'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int e = 1; e <= 3; e++) cyc(1'b1, e >= 2);
    cyc(1'b0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected samples left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
